// File: rtl/azadi_autobaud_detect_if.sv
// Bus between the auto-baud detector and its surroundings: the RX pad, the
// re-arm strobe, the LA override and the measured bit period.
interface azadi_autobaud_detect_if #(
    parameter int CNT_W = 16
);
    logic             uart_rx_i;
    logic             start_i;
    logic             la_override_i;
    logic [CNT_W-1:0] la_clks_per_bit_i;
    logic [CNT_W-1:0] clks_per_bit_o;
    logic             locked_o;
    logic             err_o;

    // Side that drives the pad/control inputs (SoC wrapper or testbench)
    modport master (
        output uart_rx_i, start_i, la_override_i, la_clks_per_bit_i,
        input  clks_per_bit_o, locked_o, err_o
    );

    // Detector side
    modport slave (
        input  uart_rx_i, start_i, la_override_i, la_clks_per_bit_i,
        output clks_per_bit_o, locked_o, err_o
    );
endinterface

// File: rtl/azadi_autobaud_detect.sv
// UART auto-baud detector: times the nine edge-to-edge intervals of a 0x55
// character on the RX pad, checks each against the start-bit interval with a
// +/-25% window and averages the first eight into clks_per_bit.
module azadi_autobaud_detect #(
    parameter int CNT_W       = 16,
    parameter int MIN_CLKS    = 16,
    parameter int DEFAULT_CPB = 104
) (
    input logic                    wb_clk_i,
    input logic                    wb_rst_i,
    azadi_autobaud_detect_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARMED, MEAS, LOCKED, ERROR} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_CLKS);
    localparam logic [CNT_W-1:0] DEF_C   = CNT_W'(DEFAULT_CPB);

    state_t           state, state_nxt;
    logic             rx_meta, rx_s, rx_q;
    logic             fall, rise, any_edge;
    logic [CNT_W-1:0] cnt, t0, result;
    logic [3:0]       edge_idx;
    logic [CNT_W+2:0] sum;
    logic [CNT_W:0]   lo, hi, ti_ext;
    logic             in_tol, pol_ok, edge_bad;

    // Average of eight intervals, rounded to nearest, truncated to CNT_W bits
    function automatic logic [CNT_W-1:0] round_div8(input logic [CNT_W+2:0] s);
        return CNT_W'((s + (CNT_W+3)'(4)) >> 3);
    endfunction

    // Two-flop synchronizer plus one delay stage for edge detection; idle high
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= bus.uart_rx_i;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    assign fall     = rx_q & ~rx_s;
    assign rise     = ~rx_q & rx_s;
    assign any_edge = fall | rise;

    // Tolerance window around T0, one bit wider so T0 + T0/4 cannot wrap
    assign lo     = {1'b0, t0} - {3'b000, t0[CNT_W-1:2]};
    assign hi     = {1'b0, t0} + {3'b000, t0[CNT_W-1:2]};
    assign ti_ext = {1'b0, cnt};
    assign in_tol = (ti_ext >= lo) && (ti_ext <= hi);
    // Even-numbered edges of 0x55 are rises (end of start bit first), odd are falls
    assign pol_ok = edge_idx[0] ? fall : rise;
    assign edge_bad = !pol_ok || ((edge_idx == 4'd0) ? (cnt < MIN_C) : !in_tol);

    // FSM state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; a start strobe re-arms from any state
    always_comb begin
        state_nxt = state;
        if (bus.start_i) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:   if (rx_s) state_nxt = ARMED;
                ARMED:  if (fall) state_nxt = MEAS;
                MEAS: begin
                    if (any_edge) begin
                        if (edge_bad)                 state_nxt = ERROR;
                        else if (edge_idx == 4'd8)    state_nxt = LOCKED;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = ERROR;
                    end
                end
                LOCKED: state_nxt = LOCKED;
                ERROR:  state_nxt = ERROR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Interval counter, edge index, running sum and the locked result
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt      <= '0;
            edge_idx <= '0;
            sum      <= '0;
            t0       <= '0;
            result   <= '0;
        end else if (bus.start_i) begin
            cnt      <= '0;
            edge_idx <= '0;
            sum      <= '0;
            t0       <= '0;
        end else if (state == ARMED && fall) begin
            cnt      <= CNT_W'(1);
            edge_idx <= '0;
            sum      <= '0;
        end else if (state == MEAS) begin
            if (any_edge) begin
                cnt      <= CNT_W'(1);
                edge_idx <= edge_idx + 4'd1;
                if (edge_idx == 4'd0) begin
                    t0  <= cnt;
                    sum <= {3'b000, cnt};
                end else if (edge_idx < 4'd8) begin
                    sum <= sum + {3'b000, cnt};
                end else if (!edge_bad) begin
                    result <= round_div8(sum);
                end
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Registered outputs; the LA override wins in every state
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bus.clks_per_bit_o <= DEF_C;
            bus.locked_o       <= 1'b0;
            bus.err_o          <= 1'b0;
        end else begin
            bus.locked_o <= !bus.start_i && (state == LOCKED);
            bus.err_o    <= !bus.start_i && (state == ERROR);
            if (bus.la_override_i)
                bus.clks_per_bit_o <= bus.la_clks_per_bit_i;
            else if (!bus.start_i && state == LOCKED)
                bus.clks_per_bit_o <= result;
            else
                bus.clks_per_bit_o <= DEF_C;
        end
    end
endmodule
